param_mem: RTL
==============

# param_mem

Parametrised single-port synchronous memory, the successor of the fixed 16x32 memory behind the existing `intf` bench interface. It adds four features:
- configurable address and data width;
- per-byte write enables;
- a configurable read-latency pipeline;
- defined write-first behaviour when a read and a write hit the same word in the same cycle.

It keeps the same enable/read/write/valid-out handshake, so the current driver and monitor extend to it with only width changes.

## Interface
Parameters:
- `Addr_width`, 4: address bits; memory holds 2**Addr_width words.
- `Data_width`, 32: word width; must be a multiple of 8.
- `Rd_latency`, 1: cycles from read issue to `valid_out`; legal range 1..4.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `EN`  in  1  operation enable; when low, no read or write is issued.
- `wr_en`  in  1  write request, qualified by `EN`.
- `rd_en`  in  1  read request, qualified by `EN`.
- `add`  in  Addr_width  word address for both read and write.
- `Data_in`  in  Data_width  write data.
- `byte_en`  in  Data_width/8  per-byte write mask; bit i controls `Data_in[8i+7:8i]`.
- `valid_out`  out  1  one-cycle pulse marking `Data_out` as valid read data.
- `Data_out`  out  Data_width  read data; holds its last value between reads.

## Operation
- Write issues on a cycle with `EN & wr_en`.
  - Only lanes with `byte_en[i]=1` in `mem[add]` are updated.
  - `byte_en=0` is a legal no-op write.
- Read issues on a cycle with `EN & rd_en`.
  - The word is sampled that cycle and enters the read pipeline.
- Simultaneous `EN & wr_en & rd_en`, same address: write-first.
  - Read data = written lanes from `Data_in`, unwritten lanes from old `mem[add]`.
- Read issued in cycle N, write to the same address in N+1: the read returns the pre-write value, because data is captured at issue.
- `EN=0` blocks issue only. In-flight reads keep advancing and still produce `valid_out`.
- Back-to-back reads are allowed every cycle; throughput is one read per cycle for any `Rd_latency`.
- Reset:
  - all memory words, pipeline stages, `valid_out` and `Data_out` go to 0;
  - in-flight reads are discarded and produce no `valid_out`;
  - requests presented during a `rst` cycle are ignored.

## Timing
- Write is visible to a read issued in the next cycle (and in the same cycle, via write-first).
- Read issued at edge N: `valid_out=1` and `Data_out` valid after edge N+Rd_latency, for exactly one cycle per read.
- `Data_out` and `valid_out` are registered; there are no combinational paths from inputs to outputs.
- `valid_out` is 0 in the first `Rd_latency` cycles after `rst` deasserts.
- Reset takes effect at the first rising edge with `rst=1`; the memory is fully cleared in that single cycle.

## Structure
- Shared package `mem_pkg`:
  - default parameter constants (`ADDR_W_DEF=4`, `DATA_W_DEF=32`, `RD_LAT_MAX=4`);
  - function `lanes(Data_width)` returning Data_width/8;
  - a packed struct `rd_stage_t {valid, data}`.
- Sub-module `rd_pipe`:
  - `Rd_latency`-deep shift register of `rd_stage_t` with synchronous clear;
  - its last stage drives `valid_out` and `Data_out`, and `Data_out` updates only when the last stage is valid.
- The top level holds the storage array, byte-masked write logic and the write-first merge mux.
- Elaboration-time assertions: `Data_width % 8 == 0` and `1 <= Rd_latency <= RD_LAT_MAX`.

## Test plan
- Reset clear (Rd_latency=2):
  - Stimulus: after reset, read addresses 0..15.
  - Response: 16 `valid_out` pulses, each with `Data_out=0`, each 2 cycles after issue.
- Byte mask:
  - Stimulus: write 0xAABBCCDD to addr 3 with `byte_en=4'b1111`, then write 0x11223344 with `byte_en=4'b0101`, then read addr 3.
  - Response: `Data_out=0xAA22CC44`.
- Write-first collision:
  - Stimulus: `mem[5]=0x12345678`, then one cycle with `wr_en=rd_en=1`, `add=5`, `Data_in=0xFFFF0000`, `byte_en=4'b1100`.
  - Response: `Data_out=0xFFFF5678`.
- Read-then-write ordering:
  - Stimulus: read addr 7 (holding 0x1) in cycle N, write 0x2 to addr 7 in N+1.
  - Response: `Data_out=0x1`; a subsequent read returns 0x2.
- Latency sweep, Rd_latency=1..4:
  - Stimulus: 8 back-to-back reads with `EN` dropped mid-burst.
  - Response: `valid_out` appears exactly `Rd_latency` cycles after each issue, with no pulse for cycles where `EN=0`.
- Reset mid-read (Rd_latency=3):
  - Stimulus: assert `rst` one cycle after a read issue.
  - Response: no `valid_out` for that read; `Data_out=0`; memory reads back 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants, lane helper and read-pipeline record for param_mem.
package mem_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;
  localparam int RD_LAT_MAX = 4;

  // Pipeline record at the default width; rd_pipe re-declares the same layout at its own width.
  typedef struct packed {
    logic                  valid;
    logic [DATA_W_DEF-1:0] data;
  } rd_stage_t;

  function automatic int lanes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rd_pipe.sv
// Read-latency shift register: carries {valid, data} from issue to the registered outputs.
module rd_pipe
  import mem_pkg::*;
#(
  parameter int Data_width = DATA_W_DEF,
  parameter int Rd_latency = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [Data_width-1:0] in_data,
  output logic                  valid_out,
  output logic [Data_width-1:0] data_out
);

  localparam int Last = Rd_latency - 1;

  typedef struct packed {
    logic                  valid;
    logic [Data_width-1:0] data;
  } stage_t;

  stage_t                stage_q [Rd_latency];
  stage_t                stage_d [Rd_latency];
  logic                  valid_out_q, valid_out_d;
  logic [Data_width-1:0] data_out_q, data_out_d;

  always_comb begin
    stage_d[0].valid = in_valid;
    stage_d[0].data  = in_data;
    for (int i = 1; i < Rd_latency; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    valid_out_d = stage_q[Last].valid;
    // Data_out only moves on a real read so it holds between reads.
    data_out_d  = stage_q[Last].valid ? stage_q[Last].data : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Rd_latency; i++) begin
        stage_q[i] <= '0;
      end
      valid_out_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      for (int i = 0; i < Rd_latency; i++) begin
        stage_q[i] <= stage_d[i];
      end
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

endmodule

// File: rtl/param_mem.sv
// Single-port synchronous memory with byte-masked writes, write-first collisions
// and a configurable read-latency pipeline.
module param_mem
  import mem_pkg::*;
#(
  parameter int Addr_width = ADDR_W_DEF,
  parameter int Data_width = DATA_W_DEF,
  parameter int Rd_latency = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         EN,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [Addr_width-1:0]        add,
  input  logic [Data_width-1:0]        Data_in,
  input  logic [lanes(Data_width)-1:0] byte_en,
  output logic                         valid_out,
  output logic [Data_width-1:0]        Data_out
);

  localparam int Depth     = 2 ** Addr_width;
  localparam int Num_lanes = lanes(Data_width);

  if (Data_width % 8 != 0) begin : g_bad_width
    $error("param_mem: Data_width must be a multiple of 8");
  end
  if (Rd_latency < 1 || Rd_latency > RD_LAT_MAX) begin : g_bad_latency
    $error("param_mem: Rd_latency must be within 1..RD_LAT_MAX");
  end

  logic                  wr_issue, rd_issue;
  logic [Data_width-1:0] mem_q [Depth];
  logic [Data_width-1:0] mem_d [Depth];
  logic [Data_width-1:0] merged_word;
  logic [Data_width-1:0] rd_word;

  assign wr_issue = EN & wr_en;
  assign rd_issue = EN & rd_en;

  // The merged word serves both the write-back and the write-first read path.
  always_comb begin
    merged_word = mem_q[add];
    for (int i = 0; i < Num_lanes; i++) begin
      if (byte_en[i]) begin
        merged_word[8*i +: 8] = Data_in[8*i +: 8];
      end
    end
    mem_d = mem_q;
    if (wr_issue) begin
      mem_d[add] = merged_word;
    end
    rd_word = wr_issue ? merged_word : mem_q[add];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  rd_pipe #(
    .Data_width(Data_width),
    .Rd_latency(Rd_latency)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_valid (rd_issue),
    .in_data  (rd_word),
    .valid_out(valid_out),
    .data_out (Data_out)
  );

endmodule
